// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single dmemory32 port between the CPU load/store path and a
// secondary debug/loader requester.
//
// The single-cycle CPU cannot stall, so it always gets the memory port with
// zero added latency. The secondary requester uses a req/ack handshake and is
// only served in cycles where the CPU leaves memory alone.
//
// A wait counter and a sticky starvation flag expose how long the secondary
// requester has been blocked.
//
// Ports
//   clock, reset                 system clock, async active-high reset
//   cpu_memread/cpu_memwrite     CPU memory access strobes
//   cpu_address/cpu_wdata        CPU address and store data
//   cpu_rdata                    read data to the CPU (mem_rdata passthrough)
//   dbg_req/dbg_we               secondary request and direction (1 = write)
//   dbg_addr/dbg_wdata           secondary word address and write data
//   dbg_ack                      one-cycle completion pulse
//   dbg_rdata                    secondary read data, held until the next read
//   dbg_busy                     secondary transaction in flight
//   mem_address/mem_wdata        address and write data to dmemory32
//   mem_write                    write enable to dmemory32
//   mem_rdata                    dmemory32 read data (one-edge read latency)
//   wait_cnt                     blocked cycles of current transaction (sat.)
//   starve_flag/starve_clr       sticky starvation flag and its clear
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no secondary transaction; dbg_req accepted here
// ISSUE   | secondary access waits for a CPU-free cycle, then goes to memory
// RD_WAIT | read address presented last cycle; capture mem_rdata this cycle
// DONE    | dbg_ack pulse
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        dbg_busy,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  wait_cnt,
    output logic        starve_flag,
    input  logic        starve_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] STARVE_LIM8 = STARVE_LIMIT[7:0];

    state_t      state_q;
    state_t      state_d;

    logic        cpu_act;
    logic        accept;
    logic        blocked;
    logic        lat_we;
    logic [29:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [7:0]  wait_inc;
    logic [7:0]  wait_d;
    logic        starve_set;

    // Byte-lane bits of the secondary address are not used: accesses are
    // always whole words.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^dbg_addr[1:0];

    assign cpu_act   = cpu_memread | cpu_memwrite;
    assign accept    = (state_q == IDLE) && dbg_req;
    assign blocked   = (state_q == ISSUE) && cpu_act;
    assign cpu_rdata = mem_rdata;
    assign dbg_busy  = (state_q != IDLE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and ack
    always_comb begin
        state_d = state_q;
        dbg_ack = 1'b0;
        case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!cpu_act) begin
                    state_d = lat_we ? DONE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                state_d = DONE;
            end
            DONE: begin
                dbg_ack = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port mux: the CPU always wins; the secondary access only
    // reaches memory in a CPU-free ISSUE cycle.
    always_comb begin
        mem_address = cpu_address;
        mem_wdata   = cpu_wdata;
        mem_write   = 1'b0;
        if (cpu_act) begin
            mem_write = cpu_memwrite;
        end else if (state_q == ISSUE) begin
            mem_address = {lat_addr, 2'b00};
            mem_wdata   = lat_wdata;
            mem_write   = lat_we;
        end
    end

    // Request latch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= dbg_we;
            lat_addr  <= dbg_addr[31:2];
            lat_wdata <= dbg_wdata;
        end
    end

    // Read capture: mem_rdata in RD_WAIT belongs to the address presented in
    // ISSUE, whatever the CPU is doing in RD_WAIT itself.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dbg_rdata <= '0;
        end else if (state_q == RD_WAIT) begin
            dbg_rdata <= mem_rdata;
        end
    end

    assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    always_comb begin
        wait_d = wait_cnt;
        if (accept) begin
            wait_d = 8'd0;
        end else if (blocked) begin
            wait_d = wait_inc;
        end
    end

    // Set is only driven while a transaction is pending, so after completion
    // the held wait_cnt does not keep the flag from being cleared.
    assign starve_set = (state_q == ISSUE) && (wait_d >= STARVE_LIM8);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt    <= 8'd0;
            starve_flag <= 1'b0;
        end else begin
            wait_cnt <= wait_d;
            if (starve_set) begin
                starve_flag <= 1'b1;
            end else if (starve_clr) begin
                starve_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_memread;
    logic        cpu_memwrite;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_busy;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [7:0]  wait_cnt;
    logic        starve_flag;
    logic        starve_clr;

    int checks;
    int failures;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_q [$];

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_memread (cpu_memread),
        .cpu_memwrite(cpu_memwrite),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .dbg_busy    (dbg_busy),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_rdata   (mem_rdata),
        .wait_cnt    (wait_cnt),
        .starve_flag (starve_flag),
        .starve_clr  (starve_clr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // dmemory32 stand-in: synchronous read of the address sampled at the edge
    always @(posedge clock) begin
        if (mem_write) mem[mem_address[11:2]] <= mem_wdata;
        mem_rdata <= mem[mem_address[11:2]];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Called right after the accept edge; lat counts the cycle we are in.
    task automatic wait_ack(input int max_cyc, output int lat);
        lat = 1;
        while (!dbg_ack && lat < max_cyc) begin
            tick();
            lat++;
        end
        checks++;
        if (!dbg_ack) begin
            failures++;
            $display("FAIL ack_timeout: no dbg_ack within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (dbg_ack !== 1'b0 || dbg_busy !== 1'b0 || dbg_rdata !== 32'h0 ||
            wait_cnt !== 8'h0 || starve_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ack=%b busy=%b rdata=%h wait=%0d starve=%b, want 0 0 0 0 0",
                     dbg_ack, dbg_busy, dbg_rdata, wait_cnt, starve_flag);
        end
        checks++;
        if (mem_address !== 32'h40 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_mux: addr=%h we=%b, want 00000040 0", mem_address, mem_write);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write;
        int lat;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h104; dbg_wdata = 32'hDEADBEEF;
        tick();
        dbg_req = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 32'h104 || mem_wdata !== 32'hDEADBEEF || dbg_busy !== 1'b1) begin
            failures++;
            $display("FAIL write_issue: we=%b addr=%h data=%h busy=%b, want 1 00000104 deadbeef 1",
                     mem_write, mem_address, mem_wdata, dbg_busy);
        end
        wait_ack(10, lat);
        checks++;
        if (lat != 2 || wait_cnt !== 8'd0) begin
            failures++;
            $display("FAIL write_latency: lat=%0d wait=%0d, want 2 0", lat, wait_cnt);
        end
        tick();
        checks++;
        if (dbg_busy !== 1'b0 || dbg_ack !== 1'b0 || mem[65] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_done: busy=%b ack=%b mem=%h, want 0 0 deadbeef", dbg_busy, dbg_ack, mem[65]);
        end
    endtask

    task automatic test_read;
        int lat;
        logic [31:0] exp;
        cpu_memwrite = 1'b1; cpu_address = 32'h104; cpu_wdata = 32'h12345678;
        #1;
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 32'h104 || mem_wdata !== 32'h12345678) begin
            failures++;
            $display("FAIL cpu_passthru: we=%b addr=%h data=%h, want 1 00000104 12345678",
                     mem_write, mem_address, mem_wdata);
        end
        tick();
        cpu_memwrite = 1'b0; cpu_address = 32'h40;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h107;
        rd_q.push_back(32'h12345678);
        tick();
        dbg_req = 1'b0;
        #1;
        checks++;
        if (mem_address !== 32'h104 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL read_issue: addr=%h we=%b, want 00000104 0", mem_address, mem_write);
        end
        wait_ack(10, lat);
        exp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hX;
        checks++;
        if (lat != 3 || dbg_rdata !== exp) begin
            failures++;
            $display("FAIL read_data: lat=%0d rdata=%h, want 3 %h", lat, dbg_rdata, exp);
        end
        tick();
        checks++;
        if (dbg_rdata !== exp) begin
            failures++;
            $display("FAIL read_hold: rdata=%h, want %h", dbg_rdata, exp);
        end
    endtask

    task automatic test_contention;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h300; dbg_wdata = 32'hCAFE0001;
        tick();
        dbg_req = 1'b0;
        cpu_memwrite = 1'b1; cpu_address = 32'h200; cpu_wdata = 32'hA5A5A5A5;
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++;
            if (mem_address !== 32'h200 || mem_wdata !== 32'hA5A5A5A5 || mem_write !== 1'b1 || dbg_ack !== 1'b0) begin
                failures++;
                $display("FAIL cpu_wins_%0d: addr=%h data=%h we=%b ack=%b, want 00000200 a5a5a5a5 1 0",
                         k, mem_address, mem_wdata, mem_write, dbg_ack);
            end
            tick();
        end
        cpu_memwrite = 1'b0; cpu_address = 32'h40;
        #1;
        checks++;
        if (wait_cnt !== 8'd5 || mem_address !== 32'h300 || mem_write !== 1'b1 || mem_wdata !== 32'hCAFE0001) begin
            failures++;
            $display("FAIL contention_issue: wait=%0d addr=%h we=%b data=%h, want 5 00000300 1 cafe0001",
                     wait_cnt, mem_address, mem_write, mem_wdata);
        end
        tick();
        checks++;
        if (dbg_ack !== 1'b1) begin
            failures++;
            $display("FAIL contention_ack: ack=%b, want 1", dbg_ack);
        end
        tick();
        checks++;
        if (mem[128] !== 32'hA5A5A5A5 || mem[192] !== 32'hCAFE0001 || wait_cnt !== 8'd5 || starve_flag !== 1'b1) begin
            failures++;
            $display("FAIL contention_result: m200=%h m300=%h wait=%0d starve=%b, want a5a5a5a5 cafe0001 5 1",
                     mem[128], mem[192], wait_cnt, starve_flag);
        end
        starve_clr = 1'b1;
        tick();
        starve_clr = 1'b0;
        checks++;
        if (starve_flag !== 1'b0) begin
            failures++;
            $display("FAIL contention_clr: starve=%b, want 0", starve_flag);
        end
    endtask

    task automatic test_starve;
        int lat;
        logic [31:0] exp;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h104;
        rd_q.push_back(32'h12345678);
        tick();
        dbg_req = 1'b0;
        cpu_memread = 1'b1; cpu_address = 32'h200;
        for (int k = 1; k <= 10; k++) begin
            starve_clr = (k == 6);
            tick();
            checks++;
            if (wait_cnt !== 8'(k) || starve_flag !== (k >= 4)) begin
                failures++;
                $display("FAIL starve_cycle_%0d: wait=%0d starve=%b, want %0d %b",
                         k, wait_cnt, starve_flag, k, (k >= 4));
            end
        end
        starve_clr = 1'b0;
        cpu_memread = 1'b0; cpu_address = 32'h40;
        #1;
        wait_ack(10, lat);
        exp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hX;
        checks++;
        if (lat != 3 || dbg_rdata !== exp) begin
            failures++;
            $display("FAIL starve_read: lat=%0d rdata=%h, want 3 %h", lat, dbg_rdata, exp);
        end
        tick();
        starve_clr = 1'b1;
        tick();
        starve_clr = 1'b0;
        checks++;
        if (starve_flag !== 1'b0 || wait_cnt !== 8'd10) begin
            failures++;
            $display("FAIL starve_clear: starve=%b wait=%0d, want 0 10", starve_flag, wait_cnt);
        end
    endtask

    task automatic test_rd_wait_cpu;
        logic [31:0] exp;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h300;
        rd_q.push_back(32'hCAFE0001);
        tick();
        dbg_req = 1'b0;
        #1;
        checks++;
        if (mem_address !== 32'h300) begin
            failures++;
            $display("FAIL rdw_issue: addr=%h, want 00000300", mem_address);
        end
        tick();
        cpu_memread = 1'b1; cpu_address = 32'h200;
        #1;
        checks++;
        if (mem_address !== 32'h200 || dbg_busy !== 1'b1 || dbg_ack !== 1'b0) begin
            failures++;
            $display("FAIL rdw_cpu: addr=%h busy=%b ack=%b, want 00000200 1 0", mem_address, dbg_busy, dbg_ack);
        end
        tick();
        cpu_memread = 1'b0; cpu_address = 32'h40;
        exp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hX;
        checks++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== exp || cpu_rdata !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL rdw_result: ack=%b rdata=%h cpu_rdata=%h, want 1 %h a5a5a5a5",
                     dbg_ack, dbg_rdata, cpu_rdata, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        logic eb_w [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic ea_w [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic eb_r [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic ea_r [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h140; dbg_wdata = 32'h0BADF00D;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (dbg_busy !== eb_w[k] || dbg_ack !== ea_w[k]) begin
                failures++;
                $display("FAIL b2b_write_%0d: busy=%b ack=%b, want %b %b", k, dbg_busy, dbg_ack, eb_w[k], ea_w[k]);
            end
        end
        dbg_we = 1'b0;
        rd_q.push_back(32'h0BADF00D);
        rd_q.push_back(32'h0BADF00D);
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (dbg_busy !== eb_r[k] || dbg_ack !== ea_r[k]) begin
                failures++;
                $display("FAIL b2b_read_%0d: busy=%b ack=%b, want %b %b", k, dbg_busy, dbg_ack, eb_r[k], ea_r[k]);
            end
            if (ea_r[k]) begin
                exp = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hX;
                checks++;
                if (dbg_rdata !== exp) begin
                    failures++;
                    $display("FAIL b2b_rdata_%0d: rdata=%h, want %h", k, dbg_rdata, exp);
                end
            end
        end
        dbg_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h3F0; dbg_wdata = 32'h5555AAAA;
        tick();
        dbg_req = 1'b0;
        #1;
        checks++;
        if (dbg_busy !== 1'b1 || mem_write !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre: busy=%b we=%b, want 1 1", dbg_busy, mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dbg_busy !== 1'b0 || mem_write !== 1'b0 || dbg_ack !== 1'b0 || wait_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid: busy=%b we=%b ack=%b wait=%0d, want 0 0 0 0",
                     dbg_busy, mem_write, dbg_ack, wait_cnt);
        end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (dbg_ack !== 1'b0 || dbg_busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_after_%0d: ack=%b busy=%b, want 0 0", k, dbg_ack, dbg_busy);
            end
        end
        checks++;
        if (mem[252] !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_mem: mem=%h, want 00000000", mem[252]);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset = 1'b1;
        cpu_memread = 1'b0; cpu_memwrite = 1'b0;
        cpu_address = 32'h40; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
        starve_clr = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_contention();
        test_starve();
        test_rd_wait_cpu();
        test_back_to_back();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
